// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_pkg : shared frame-FSM state type and width defaults   rev 1.0   |
// +----------------------------------------------------------------------+
package spi_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_RD_LOAD   = 3'd2,
    ST_READ      = 3'd3,
    ST_WRITE     = 3'd4,
    ST_WR_STROBE = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_shiftreg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_shiftreg : MSB-first shift register, parallel load     rev 1.0   |
// +----------------------------------------------------------------------+
module spi_shiftreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_data,
  input  logic         i_shift,
  input  logic         i_serial,
  output logic [W-1:0] o_q,
  output logic         o_serial
);

  logic [W-1:0] r_q;

  // Load wins over shift so a parallel load is never corrupted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_data;
    end else if (i_shift) begin
      r_q <= {r_q[W-2:0], i_serial};
    end
  end

  assign o_q      = r_q;
  assign o_serial = r_q[W-1];

endmodule
`default_nettype wire

// File: rtl/spi_frame_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_frame_fsm : mode-0 SPI slave frame decoder (addr, R/W, data)     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module spi_frame_fsm
  import spi_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk_pos,
  input  logic              sclk_neg,
  input  logic              cs_n,
  input  logic              mosi,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  output logic              miso,
  output logic              miso_oe
);

  localparam int CW  = $clog2(ADDR_W + 2);
  // Last frame bit is taken straight from mosi, so the receive register
  // only has to hold the bits before it.
  localparam int RXW = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
  localparam logic [CW-1:0] c_addr_last = CW'(ADDR_W);
  localparam logic [CW-1:0] c_data_last = CW'(DATA_W - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic              w_cnt_clr;
  logic              w_cnt_inc;
  logic              w_rx_shift;
  logic              w_tx_load;
  logic              w_tx_shift;
  logic              w_addr_lat;
  logic              w_wr_lat;
  logic [RXW-1:0]    w_rx_q;
  logic              w_unused_rx_msb;
  logic [DATA_W-1:0] w_unused_tx_q;
  logic              w_tx_so;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_rx_shift  = 1'b0;
    w_tx_load   = 1'b0;
    w_tx_shift  = 1'b0;
    w_addr_lat  = 1'b0;
    w_wr_lat    = 1'b0;
    // Chip-select release aborts everything except a strobe already issued.
    if (cs_n && r_state != ST_WR_STROBE) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_ADDR;
          w_cnt_clr   = 1'b1;
        end
        ST_ADDR: begin
          if (sclk_pos) begin
            w_rx_shift = 1'b1;
            if (r_cnt == c_addr_last) begin
              w_addr_lat  = 1'b1;
              w_cnt_clr   = 1'b1;
              w_state_nxt = mosi ? ST_RD_LOAD : ST_WRITE;
            end else begin
              w_cnt_inc = 1'b1;
            end
          end
        end
        ST_RD_LOAD: begin
          w_tx_load   = 1'b1;
          w_state_nxt = ST_READ;
        end
        ST_READ: begin
          if (sclk_pos) begin
            if (r_cnt == c_data_last) w_state_nxt = ST_DONE;
            else                      w_cnt_inc   = 1'b1;
          end else if (sclk_neg && r_cnt != '0) begin
            // Zero count means this is the address's trailing edge.
            w_tx_shift = 1'b1;
          end
        end
        ST_WRITE: begin
          if (sclk_pos) begin
            w_rx_shift = 1'b1;
            if (r_cnt == c_data_last) begin
              w_wr_lat    = 1'b1;
              w_state_nxt = ST_WR_STROBE;
            end else begin
              w_cnt_inc = 1'b1;
            end
          end
        end
        ST_WR_STROBE: w_state_nxt = ST_DONE;
        ST_DONE:      w_state_nxt = ST_DONE;
        default:      w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      addr    <= '0;
      wr_data <= '0;
    end else begin
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
      if (w_addr_lat) addr    <= w_rx_q[ADDR_W-1:0];
      if (w_wr_lat)   wr_data <= {w_rx_q[DATA_W-2:0], mosi};
    end
  end

  spi_shiftreg #(.W(RXW)) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (1'b0),
    .i_load_data ('0),
    .i_shift     (w_rx_shift),
    .i_serial    (mosi),
    .o_q         (w_rx_q),
    .o_serial    (w_unused_rx_msb)
  );

  spi_shiftreg #(.W(DATA_W)) u_tx (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_tx_load),
    .i_load_data (rd_data),
    .i_shift     (w_tx_shift),
    .i_serial    (1'b0),
    .o_q         (w_unused_tx_q),
    .o_serial    (w_tx_so)
  );

  assign wr_en   = (r_state == ST_WR_STROBE);
  assign miso_oe = (r_state == ST_READ);
  assign miso    = miso_oe & w_tx_so;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spi_frame_fsm : scoreboard bench for spi_frame_fsm      rev 1.0   |
// +----------------------------------------------------------------------+
module tb_spi_frame_fsm;

  logic       clk = 1'b0;
  logic       rst_n, sclk_pos, sclk_neg, cs_n, mosi;
  logic [7:0] rd_data;
  logic [6:0] addr;
  logic [7:0] wr_data;
  logic       wr_en, miso, miso_oe;

  logic [7:0]  mem [128];
  logic [14:0] wq [$];
  logic        bq [$];
  logic        oe_ok = 1'b0;
  logic [6:0]  exp_addr = '0;
  logic [7:0]  exp_wdata = '0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  assign rd_data = mem[addr];

  spi_frame_fsm #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk_pos (sclk_pos),
    .sclk_neg (sclk_neg),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .rd_data  (rd_data),
    .addr     (addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .miso     (miso),
    .miso_oe  (miso_oe)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (!miso_oe) chk("miso_idle_zero", 32'(miso), 32'd0);
    if (miso_oe && !oe_ok) chk("miso_oe_outside_read", 32'(miso_oe), 32'd0);
    if (wr_en) begin
      if (wq.size() == 0) begin
        chk("unexpected_wr_en", 32'(wr_en), 32'd0);
      end else begin
        logic [14:0] e;
        e = wq.pop_front();
        chk("wr_addr", 32'(addr), 32'(e[14:8]));
        chk("wr_data", 32'(wr_data), 32'(e[7:0]));
      end
    end
    if (sclk_pos && miso_oe) begin
      if (bq.size() == 0) begin
        chk("unexpected_read_bit", 32'(miso_oe), 32'd0);
      end else begin
        logic eb;
        eb = bq.pop_front();
        chk("miso_bit", 32'(miso), 32'(eb));
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_miso_oe", 32'(miso_oe), 32'd0);
  endtask

  // One frame of np SCLK pulse pairs; rst_at >= 0 pulses reset before that pulse.
  task automatic frame(input logic [6:0] a, input logic rw, input logic [7:0] d,
                       input int np, input logic both, input int rst_at);
    int n_eff;
    n_eff = (rst_at >= 0 && rst_at < np) ? rst_at : np;
    if (n_eff >= 8) exp_addr = a;
    if (!rw && n_eff >= 16) begin
      wq.push_back({a, d});
      exp_wdata = d;
    end
    if (rw) begin
      logic [7:0] rv;
      rv = mem[a];
      for (int k = 0; k < n_eff - 8 && k < 8; k++) bq.push_back(rv[7-k]);
    end
    cs_n = 1'b0;
    tick(2);
    for (int i = 0; i < np; i++) begin
      logic b;
      if (i == rst_at) begin
        rst_n = 1'b0;
        cs_n  = 1'b1;
        tick(1);
        check_reset_outputs();
        rst_n     = 1'b1;
        oe_ok     = 1'b0;
        exp_addr  = '0;
        exp_wdata = '0;
        tick(1);
        return;
      end
      if (i < 7)       b = a[6-i];
      else if (i == 7) b = rw;
      else if (i < 16) b = d[15-i];
      else             b = 1'($urandom);
      mosi = b;
      tick(2);
      sclk_pos = 1'b1;
      sclk_neg = both;
      if (rw && i == 7) oe_ok = 1'b1;
      tick(1);
      sclk_pos = 1'b0;
      sclk_neg = 1'b0;
      tick(2);
      sclk_neg = 1'b1;
      tick(1);
      sclk_neg = 1'b0;
      tick(1);
    end
    cs_n = 1'b1;
    tick(1);
    oe_ok = 1'b0;
    chk("oe_after_cs_high", 32'(miso_oe), 32'd0);
    chk("addr_hold", 32'(addr), 32'(exp_addr));
    chk("wr_data_hold", 32'(wr_data), 32'(exp_wdata));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 128; k++) mem[k] = 8'($urandom);
    mem[7'h2A] = 8'h3C;
    rst_n = 1'b0; cs_n = 1'b1; mosi = 1'b0; sclk_pos = 1'b0; sclk_neg = 1'b0;
    tick(3);
    check_reset_outputs();
    rst_n = 1'b1;
    tick(2);

    frame(7'h15, 1'b0, 8'hA5, 16, 1'b0, -1);
    frame(7'h2A, 1'b1, 8'h00, 16, 1'b0, -1);
    frame(7'h33, 1'b0, 8'h5E, 12, 1'b0, -1);
    tick(3);
    frame(7'h2A, 1'b1, 8'h00, 16, 1'b0, 11);
    frame(7'h01, 1'b0, 8'hFF, 16, 1'b0, -1);
    frame(7'h44, 1'b0, 8'h81, 20, 1'b0, -1);
    frame(7'h12, 1'b0, 8'h34, 16, 1'b0, -1);
    frame(7'h56, 1'b0, 8'h78, 16, 1'b0, -1);
    frame(7'h2A, 1'b1, 8'h00, 16, 1'b1, -1);

    for (int f = 0; f < 30; f++) begin
      logic [6:0] ra;
      logic       rrw, rb;
      logic [7:0] rd;
      int         rn;
      ra  = 7'($urandom);
      rrw = 1'($urandom);
      rd  = 8'($urandom);
      rb  = ($urandom_range(0, 3) == 0);
      rn  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : 16 + $urandom_range(0, 4);
      frame(ra, rrw, rd, rn, rb, -1);
      tick($urandom_range(0, 3));
    end

    tick(10);
    chk("write_queue_drained", 32'(wq.size()), 32'd0);
    chk("read_queue_drained", 32'(bq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_frame_fsm.md
SPI_FRAME_FSM -- requirements
Module: spi_frame_fsm

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, address width in bits.
REQ-002 SHALL have parameter DATA_W, default 8, data width in bits.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port sclk_pos  input  1  one-clk pulse per conditioned SCLK rising edge, from the input conditioner.
REQ-006 SHALL have port sclk_neg  input  1  one-clk pulse per conditioned SCLK falling edge, from the input conditioner.
REQ-007 SHALL have port cs_n  input  1  conditioned chip select, active low.
REQ-008 SHALL have port mosi  input  1  conditioned serial data in.
REQ-009 SHALL have port rd_data  input  DATA_W  combinational read data for addr.
REQ-010 SHALL have port addr  output  ADDR_W  latched frame address.
REQ-011 SHALL have port wr_data  output  DATA_W  latched write data.
REQ-012 SHALL have port wr_en  output  1  one-clk write strobe.
REQ-013 SHALL have port miso  output  1  serial data out, valid when miso_oe=1.
REQ-014 SHALL have port miso_oe  output  1  MISO drive enable; the pad tristates when 0.

Function
REQ-015 SHALL implement SPI mode 0 frames, MSB first: ADDR_W address bits, 1 R/W bit (1=read), then DATA_W data bits.
REQ-016 SHALL use states IDLE, ADDR, RD_LOAD, READ, WRITE, WR_STROBE, DONE.
REQ-017 IDLE: cs_n=0 -> ADDR, bit counter cleared.
REQ-018 ADDR: each sclk_pos shifts mosi into the receive shift register LSB and increments the counter.
REQ-019 ADDR: on the (ADDR_W+1)th sclk_pos, addr latches the address bits; R/W=1 -> RD_LOAD, R/W=0 -> WRITE; counter cleared.
REQ-020 RD_LOAD: lasts exactly 1 clk; loads rd_data into the transmit shift register -> READ.
REQ-021 READ: miso_oe=1 and miso = transmit register MSB.
REQ-022 READ: each sclk_pos increments the counter.
REQ-023 READ: each sclk_neg shifts the transmit register left by 1, but only when the counter is nonzero; this ignores the address byte's trailing falling edge.
REQ-024 READ: the DATA_W-th sclk_pos -> DONE.
REQ-025 WRITE: each sclk_pos shifts mosi in.
REQ-026 WRITE: the DATA_W-th sclk_pos latches the received byte into wr_data -> WR_STROBE.
REQ-027 WR_STROBE: wr_en=1 for exactly 1 clk -> DONE.
REQ-028 DONE: ignores SCLK pulses; cs_n=1 -> IDLE.
REQ-029 cs_n=1 in any state other than WR_STROBE SHALL force IDLE on the next clk, with no wr_en; miso_oe SHALL be 0 from that clk.
REQ-030 WR_STROBE SHALL complete even if cs_n rises during it.
REQ-031 If sclk_pos and sclk_neg are asserted in the same clk, sclk_pos SHALL take priority and sclk_neg SHALL be ignored.
REQ-032 miso_oe SHALL be 1 only in READ.
REQ-033 miso SHALL be 0 whenever miso_oe=0.
REQ-034 addr and wr_data SHALL hold their values until the next latch event.
REQ-035 The bit counter SHALL be $clog2(ADDR_W+2) bits wide and SHALL never wrap within a frame.

Reset
REQ-036 rst_n=0 at a clk edge SHALL force IDLE, and clear the counter and both shift registers.
REQ-037 Reset SHALL set addr=0, wr_data=0, wr_en=0, miso=0, miso_oe=0.
REQ-038 Reset mid-frame SHALL abort the frame with no wr_en.
REQ-039 After reset release, the FSM SHALL wait in IDLE until cs_n is observed low; it SHALL NOT resume a frame already in progress.

Structure
REQ-040 A shared package spi_pkg SHALL hold the state enum type and the ADDR_W and DATA_W defaults.
REQ-041 A sub-module spi_shiftreg (parallel load, serial in, serial out, shift enable) SHALL be instantiated twice, once for receive and once for transmit.

Verification
REQ-042 Write: frame addr 0x15, W, data 0xA5 -> exactly one wr_en pulse; addr=0x15, wr_data=0xA5 during the pulse.
REQ-043 Read: rd_data returns 0x3C for addr 0x2A; read frame -> miso sampled at 8 data sclk_pos = 0,0,1,1,1,1,0,0; miso_oe=1 only in READ.
REQ-044 Abort: cs_n=1 after 4 write data bits -> IDLE next clk; no wr_en; addr retains the frame's address.
REQ-045 Reset mid-read at data bit 3 -> all outputs 0 next clk; a following full write frame (0x01, 0xFF) succeeds.
REQ-046 Extra clocks: 20 sclk pulse pairs in one write frame -> single wr_en; pulses after the 16th are ignored in DONE.
REQ-047 Back-to-back: two write frames separated by 1 clk of cs_n=1 -> two wr_en pulses with the correct addr/data each.
